// File: rtl/zmod_link_rx.sv
// ZMOD 4-lane loopback receiver: sync hunt, word assembly, counter-payload check.
// Optional ZMOD_RX_STATS_EN adds the frame_cnt output (good sync slots seen).
module zmod_link_rx #(
  parameter logic [31:0] SYNC_WORD   = 32'hA5C3_5A3C,
  parameter int          PAYLOAD_LEN = 16,
  parameter int          LOCK_FRAMES = 4,
  parameter int          LOSS_FRAMES = 2,
  parameter int          ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       d_in,
  input  logic             en,
  input  logic             clear,
  output logic [31:0]      word_out,
  output logic             word_valid,
  output logic             locked,
  output logic [1:0]       state,
  output logic             data_err,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
`ifdef ZMOD_RX_STATS_EN
  ,
  output logic [31:0]      frame_cnt
`endif
);

  localparam int WC_W = $clog2(PAYLOAD_LEN + 1);
  localparam int GC_W = $clog2(LOCK_FRAMES + 1);
  localparam int BC_W = $clog2(LOSS_FRAMES + 1);

  typedef enum logic [1:0] {HUNT = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_e;

  state_e            st_q, st_d;
  logic [31:0]       sh_q, sh_d, sh_nx;
  logic [2:0]        nib_q, nib_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [GC_W-1:0]   good_q, good_d;
  logic [BC_W-1:0]   bad_q, bad_d;
  logic              seed_q, seed_d;
  logic [31:0]       exp_q, exp_d;
  logic [31:0]       word_q, word_d;
  logic              wv_q, wv_d, de_q, de_d, se_q, se_d, lk_q, lk_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              err_inc;
`ifdef ZMOD_RX_STATS_EN
  logic [31:0]       fr_q, fr_d;
  logic              fr_inc;
`endif

  always_comb begin
    st_d    = st_q;
    sh_d    = sh_q;
    nib_d   = nib_q;
    wc_d    = wc_q;
    good_d  = good_q;
    bad_d   = bad_q;
    seed_d  = seed_q;
    exp_d   = exp_q;
    word_d  = word_q;
    wv_d    = 1'b0;
    de_d    = 1'b0;
    se_d    = 1'b0;
    err_inc = 1'b0;
`ifdef ZMOD_RX_STATS_EN
    fr_inc  = 1'b0;
`endif
    sh_nx   = {sh_q[27:0], d_in};
    if (en) begin
      sh_d = sh_nx;
      case (st_q)
        HUNT: begin
          if (sh_nx == SYNC_WORD) begin
            st_d   = ALIGN;
            nib_d  = 3'd0;
            wc_d   = '0;
            good_d = GC_W'(1);
            bad_d  = '0;
            seed_d = 1'b1;
          end
        end
        ALIGN, LOCKED: begin
          if (nib_q == 3'd7) begin
            nib_d = 3'd0;
            if (wc_q == WC_W'(PAYLOAD_LEN)) begin
              wc_d = '0;
              if (sh_nx == SYNC_WORD) begin
                bad_d = '0;
`ifdef ZMOD_RX_STATS_EN
                fr_inc = 1'b1;
`endif
                if (good_q < GC_W'(LOCK_FRAMES)) good_d = good_q + GC_W'(1);
                if (st_q == ALIGN && good_d == GC_W'(LOCK_FRAMES)) st_d = LOCKED;
              end else begin
                se_d    = 1'b1;
                err_inc = 1'b1;
                if (st_q == ALIGN) st_d = HUNT;
                else if (bad_q == BC_W'(LOSS_FRAMES - 1)) st_d = HUNT;
                else bad_d = bad_q + BC_W'(1);
              end
            end else begin
              wc_d   = wc_q + WC_W'(1);
              word_d = sh_nx;
              wv_d   = 1'b1;
              exp_d  = sh_nx + 32'd1;
              seed_d = 1'b0;
              // first word after acquiring sync only seeds the expected counter
              if (!seed_q && sh_nx != exp_q) begin
                de_d    = 1'b1;
                err_inc = 1'b1;
              end
            end
          end else begin
            nib_d = nib_q + 3'd1;
          end
        end
        default: st_d = HUNT;
      endcase
    end
    lk_d = (st_d == LOCKED);

    err_d = err_q;
    if (clear) err_d = '0;
    else if (err_inc && err_q != '1) err_d = err_q + ERR_W'(1);
`ifdef ZMOD_RX_STATS_EN
    fr_d = fr_q;
    if (clear) fr_d = '0;
    else if (fr_inc) fr_d = fr_q + 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= HUNT;
      sh_q   <= '0;
      nib_q  <= '0;
      wc_q   <= '0;
      good_q <= '0;
      bad_q  <= '0;
      seed_q <= 1'b0;
      exp_q  <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
      de_q   <= 1'b0;
      se_q   <= 1'b0;
      lk_q   <= 1'b0;
      err_q  <= '0;
`ifdef ZMOD_RX_STATS_EN
      fr_q   <= '0;
`endif
    end else begin
      st_q   <= st_d;
      sh_q   <= sh_d;
      nib_q  <= nib_d;
      wc_q   <= wc_d;
      good_q <= good_d;
      bad_q  <= bad_d;
      seed_q <= seed_d;
      exp_q  <= exp_d;
      word_q <= word_d;
      wv_q   <= wv_d;
      de_q   <= de_d;
      se_q   <= se_d;
      lk_q   <= lk_d;
      err_q  <= err_d;
`ifdef ZMOD_RX_STATS_EN
      fr_q   <= fr_d;
`endif
    end
  end

  assign word_out   = word_q;
  assign word_valid = wv_q;
  assign locked     = lk_q;
  assign state      = st_q;
  assign data_err   = de_q;
  assign sync_err   = se_q;
  assign err_cnt    = err_q;
`ifdef ZMOD_RX_STATS_EN
  assign frame_cnt  = fr_q;
`endif

endmodule
